// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its two-requester share controller.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_EQ  = 3'b000;
    localparam logic [OP_W-1:0] OP_GT  = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_AND = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_ADD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; carry/overflow are only driven for add and sub.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              of
);

    logic [DATA_W:0] sum;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        of     = 1'b0;
        sum    = '0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                of     = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            // Subtract as a + ~b + 1, so carry means "no borrow".
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                of     = (a[DATA_W-1] != b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_GT:  result = DATA_W'($signed(a) > $signed(b));
            OP_EQ:  result = DATA_W'(a == b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: round-robin accept, one execute cycle,
// then a held valid/ready response with per-requester saturating completion counts.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req0_a,
    input  logic [3:0]        req0_b,
    input  logic [2:0]        req0_op,
    input  logic [3:0]        req1_a,
    input  logic [3:0]        req1_b,
    input  logic [2:0]        req1_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [3:0]        rsp_result,
    output logic              rsp_carry,
    output logic              rsp_of,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1
);

    state_t            state;
    state_t            state_nxt;
    logic              ptr;
    logic              owner;
    alu_req_t          opnd;
    alu_req_t          sel;
    logic [1:0]        grant;
    logic              grant_idx;
    logic              accept;
    logic              complete;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_of;

    // Round-robin grant: a lone request always wins, the pointer breaks ties.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        grant_idx = grant[1];
        sel = grant_idx ? alu_req_t'{a: req1_a, b: req1_b, op: req1_op}
                        : alu_req_t'{a: req0_a, b: req0_b, op: req0_op};
    end

    assign accept   = |(req_valid & req_ready);
    assign complete = (state == RESP) && rsp_ready[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        busy      = (state != IDLE);
        if ((state == IDLE) && !rst) begin
            req_ready = grant;
        end
    end

    alu u_alu (
        .a      (opnd.a),
        .b      (opnd.b),
        .op     (opnd.op),
        .result (alu_result),
        .carry  (alu_carry),
        .of     (alu_of)
    );

    // Operand capture, response register and completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            opnd       <= '0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_of     <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            if (accept) begin
                opnd  <= sel;
                owner <= grant_idx;
                ptr   <= ~grant_idx;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_of     <= alu_of;
                rsp_valid  <= owner ? 2'b10 : 2'b01;
            end
            if (complete) begin
                rsp_valid <= 2'b00;
                if (!owner && (done_cnt0 != '1)) begin
                    done_cnt0 <= done_cnt0 + CNT_W'(1);
                end
                if (owner && (done_cnt1 != '1)) begin
                    done_cnt1 <= done_cnt1 + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed plus randomized checks of alu_share_ctrl against an arithmetic reference model.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_of, busy;
    logic [7:0] done_cnt0, done_cnt1;

    logic [1:0] s_req_ready, s_rsp_valid;
    logic [3:0] s_rsp_result;
    logic       s_rsp_carry, s_rsp_of, s_busy;
    logic [1:0] s_done_cnt0, s_done_cnt1;

    int vec  = 0;
    int errs = 0;
    int ptr_m = 0;
    int cnt_m [2];

    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_of(rsp_of), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_share_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
        .rsp_carry(s_rsp_carry), .rsp_of(s_rsp_of), .busy(s_busy),
        .done_cnt0(s_done_cnt0), .done_cnt1(s_done_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {of, carry, result} computed with plain integer arithmetic.
    function automatic logic [5:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        c = 1'b0;
        o = 1'b0;
        r = 0;
        case (op)
            3'b111: begin r = ua + ub; c = (r > 15); o = (sa + sb > 7) || (sa + sb < -8); end
            3'b110: begin r = ua - ub; c = (ua >= ub); o = (sa - sb > 7) || (sa - sb < -8); end
            3'b101: r = 15 - ua;
            3'b100: r = ua & ub;
            3'b011: r = ua | ub;
            3'b010: r = ua ^ ub;
            3'b001: r = (sa > sb) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        return {o, c, 4'(r & 15)};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_cnt0"},   32'(done_cnt0),   32'(sat(cnt_m[0], 255)));
        chk({tag, "_cnt1"},   32'(done_cnt1),   32'(sat(cnt_m[1], 255)));
        chk({tag, "_scnt0"},  32'(s_done_cnt0), 32'(sat(cnt_m[0], 3)));
        chk({tag, "_scnt1"},  32'(s_done_cnt1), 32'(sat(cnt_m[1], 3)));
    endtask

    // One full transaction starting at a negedge while the DUT is IDLE.
    task automatic run_op(input logic [1:0] vmask,
                          input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                          input int hold);
        int g;
        logic [5:0] exp;
        logic [1:0] gm;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        req_valid = vmask;
        rsp_ready = 2'b00;
        g = (vmask == 2'b11) ? ptr_m : (vmask[1] ? 1 : 0);
        gm = (g == 1) ? 2'b10 : 2'b01;
        exp = (g == 1) ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
        #1;
        chk("grant", 32'(req_ready), 32'(gm));
        chk("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        ptr_m = 1 - g;
        req_valid[g] = 1'b0;
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(gm));
            chk("rsp_result", 32'(rsp_result), 32'(exp[3:0]));
            chk("rsp_carry", 32'(rsp_carry), 32'(exp[4]));
            chk("rsp_of", 32'(rsp_of), 32'(exp[5]));
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            rsp_ready[1-g] = 1'($urandom_range(1, 0));
            rsp_ready[g] = (h == hold);
            @(negedge clk);
        end
        cnt_m[g]++;
        rsp_ready = 2'b00;
        chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk_counts("done");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        ptr_m = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready2", 32'(req_ready), 32'd0);
        chk_counts("rst");
        rst = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 3'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 3'd0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;

        // Power-on reset state
        @(negedge clk);
        @(negedge clk);
        chk("por_req_ready", 32'(req_ready), 32'd0);
        chk("por_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("por_result", 32'(rsp_result), 32'd0);
        chk("por_carry", 32'(rsp_carry), 32'd0);
        chk("por_of", 32'(rsp_of), 32'd0);
        chk("por_busy", 32'(busy), 32'd0);
        chk_counts("por");
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);

        // Single add, then sub with borrow
        run_op(2'b01, 4'b0111, 4'b0001, 3'b111, 4'd0, 4'd0, 3'd0, 0);
        run_op(2'b10, 4'd0, 4'd0, 3'd0, 4'b0011, 4'b0101, 3'b110, 0);

        // Contention: grants alternate
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 4'b0101, 4'b0101, 3'b000, 4'b0001, 4'b1111, 3'b001, 0);
        end

        // Backpressure held for 5 cycles
        run_op(2'b01, 4'b1000, 4'b1000, 3'b111, 4'd0, 4'd0, 3'd0, 5);

        // Reset while in EXEC: operation dropped
        req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'b111;
        req_valid = 2'b01;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) begin
            run_op(2'b01, 4'(i), 4'(i + 3), 3'b111, 4'd0, 4'd0, 3'd0, 0);
        end
        chk("sat_scnt0", 32'(s_done_cnt0), 32'd3);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(3, 1)),
                   4'($urandom), 4'($urandom), 3'($urandom),
                   4'($urandom), 4'($urandom), 3'($urandom),
                   int'($urandom_range(3, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
